// File: rtl/jtag_tap_pkg.sv
// TAP state encodings, default opcodes and the IR capture pattern shared by the TAP responder.
// Constants only; no timing or flow control of its own.
package jtag_tap_pkg;

   localparam logic [3:0] ST_TLR    = 4'hF;
   localparam logic [3:0] ST_RTI    = 4'hC;
   localparam logic [3:0] ST_SEL_DR = 4'h7;
   localparam logic [3:0] ST_CAP_DR = 4'h6;
   localparam logic [3:0] ST_SH_DR  = 4'h2;
   localparam logic [3:0] ST_EX1_DR = 4'h1;
   localparam logic [3:0] ST_PAU_DR = 4'h3;
   localparam logic [3:0] ST_EX2_DR = 4'h0;
   localparam logic [3:0] ST_UPD_DR = 4'h5;
   localparam logic [3:0] ST_SEL_IR = 4'h4;
   localparam logic [3:0] ST_CAP_IR = 4'hE;
   localparam logic [3:0] ST_SH_IR  = 4'hA;
   localparam logic [3:0] ST_EX1_IR = 4'h9;
   localparam logic [3:0] ST_PAU_IR = 4'hB;
   localparam logic [3:0] ST_EX2_IR = 4'h8;
   localparam logic [3:0] ST_UPD_IR = 4'hD;

   localparam logic [3:0] DEF_INSTR_IDCODE = 4'b0010;
   localparam logic [3:0] DEF_INSTR_USER   = 4'b1000;
   localparam logic [1:0] IR_CAPTURE       = 2'b01;

   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER} dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP controller stepped by tms on tck rising edge; strobes decode the current state.
// Latency: one tck per transition; no backpressure, the external driver paces everything.
module jtag_tap_fsm
   import jtag_tap_pkg::*;
(
   input  logic       tck,
   input  logic       rst,
   input  logic       tms,
   output logic [3:0] state,
   output logic [3:0] state_next,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir
);

   logic [3:0] state_q;
   logic [3:0] state_d;

   always_comb begin
      state_d = ST_TLR;
      case (state_q)
         ST_TLR:    state_d = tms ? ST_TLR    : ST_RTI;
         ST_RTI:    state_d = tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR: state_d = tms ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR: state_d = tms ? ST_EX1_DR : ST_SH_DR;
         ST_SH_DR:  state_d = tms ? ST_EX1_DR : ST_SH_DR;
         ST_EX1_DR: state_d = tms ? ST_UPD_DR : ST_PAU_DR;
         ST_PAU_DR: state_d = tms ? ST_EX2_DR : ST_PAU_DR;
         ST_EX2_DR: state_d = tms ? ST_UPD_DR : ST_SH_DR;
         ST_UPD_DR: state_d = tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR: state_d = tms ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR: state_d = tms ? ST_EX1_IR : ST_SH_IR;
         ST_SH_IR:  state_d = tms ? ST_EX1_IR : ST_SH_IR;
         ST_EX1_IR: state_d = tms ? ST_UPD_IR : ST_PAU_IR;
         ST_PAU_IR: state_d = tms ? ST_EX2_IR : ST_PAU_IR;
         ST_EX2_IR: state_d = tms ? ST_UPD_IR : ST_SH_IR;
         ST_UPD_IR: state_d = tms ? ST_SEL_DR : ST_RTI;
         default:   state_d = ST_TLR;
      endcase
   end

   always_ff @(posedge tck or posedge rst) begin
      if (rst) state_q <= ST_TLR;
      else     state_q <= state_d;
   end

   assign state      = state_q;
   assign state_next = state_d;
   assign capture_dr = (state_q == ST_CAP_DR);
   assign shift_dr   = (state_q == ST_SH_DR);
   assign update_dr  = (state_q == ST_UPD_DR);
   assign capture_ir = (state_q == ST_CAP_IR);
   assign shift_ir   = (state_q == ST_SH_IR);
   assign update_ir  = (state_q == ST_UPD_IR);

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP with IR plus IDCODE/BYPASS/USER data registers; USER is a parallel capture/update port.
// Latency: tdi shifts on tck rise, tdo launches on the following fall; no backpressure (tck-paced).
module jtag_tap_responder
   import jtag_tap_pkg::*;
#(
   parameter int                     IR_WIDTH     = 4,
   parameter logic [31:0]            IDCODE_VALUE = 32'h149511C3,
   parameter int                     USER_WIDTH   = 32,
   parameter logic [IR_WIDTH-1:0]    INSTR_IDCODE = IR_WIDTH'(DEF_INSTR_IDCODE),
   parameter logic [IR_WIDTH-1:0]    INSTR_USER   = IR_WIDTH'(DEF_INSTR_USER)
) (
   input  logic                  tck,
   input  logic                  rst,
   input  logic                  tms,
   input  logic                  tdi,
   output logic                  tdo,
   output logic                  tdo_oe,
   output logic [3:0]            tap_state,
   output logic [IR_WIDTH-1:0]   ir,
   input  logic [USER_WIDTH-1:0] user_capture,
   output logic [USER_WIDTH-1:0] user_data,
   output logic                  user_update
);

   logic [3:0] state_next;
   logic       capture_dr, shift_dr, update_dr;
   logic       capture_ir, shift_ir, update_ir;

   jtag_tap_fsm u_fsm (
      .tck        (tck),
      .rst        (rst),
      .tms        (tms),
      .state      (tap_state),
      .state_next (state_next),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir)
   );

   logic [IR_WIDTH-1:0]   ir_q, ir_d;
   logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
   logic [31:0]           idcode_shift_q, idcode_shift_d;
   logic                  bypass_q, bypass_d;
   logic [USER_WIDTH-1:0] user_shift_q, user_shift_d;
   logic [USER_WIDTH-1:0] user_data_q, user_data_d;
   logic                  tdo_q, tdo_d;
   logic                  tdo_oe_q, tdo_oe_d;
   dr_sel_e               dr_sel;

   always_comb begin
      if (ir_q == INSTR_IDCODE)    dr_sel = DR_IDCODE;
      else if (ir_q == INSTR_USER) dr_sel = DR_USER;
      else                         dr_sel = DR_BYPASS;
   end

   always_comb begin
      ir_d           = ir_q;
      ir_shift_d     = ir_shift_q;
      idcode_shift_d = idcode_shift_q;
      bypass_d       = bypass_q;
      user_shift_d   = user_shift_q;
      user_data_d    = user_data_q;

      if (capture_ir) ir_shift_d = IR_WIDTH'(IR_CAPTURE);
      if (shift_ir)   ir_shift_d = IR_WIDTH'({tdi, ir_shift_q} >> 1);
      if (update_ir)  ir_d       = ir_shift_q;
      // Entering Test-Logic-Reset by tms alone must behave like a reset of the instruction.
      if (state_next == ST_TLR) ir_d = INSTR_IDCODE;

      case (dr_sel)
         DR_IDCODE: begin
            if (capture_dr) idcode_shift_d = IDCODE_VALUE;
            if (shift_dr)   idcode_shift_d = {tdi, idcode_shift_q[31:1]};
         end
         DR_USER: begin
            if (capture_dr) user_shift_d = user_capture;
            if (shift_dr)   user_shift_d = USER_WIDTH'({tdi, user_shift_q} >> 1);
            if (update_dr)  user_data_d  = user_shift_q;
         end
         default: begin
            if (capture_dr) bypass_d = 1'b0;
            if (shift_dr)   bypass_d = tdi;
         end
      endcase
   end

   always_comb begin
      tdo_d    = 1'b0;
      tdo_oe_d = shift_dr | shift_ir;
      if (shift_ir) begin
         tdo_d = ir_shift_q[0];
      end else if (shift_dr) begin
         case (dr_sel)
            DR_IDCODE: tdo_d = idcode_shift_q[0];
            DR_USER:   tdo_d = user_shift_q[0];
            default:   tdo_d = bypass_q;
         endcase
      end
   end

   always_ff @(posedge tck or posedge rst) begin
      if (rst) begin
         ir_q           <= INSTR_IDCODE;
         ir_shift_q     <= '0;
         idcode_shift_q <= '0;
         bypass_q       <= 1'b0;
         user_shift_q   <= '0;
         user_data_q    <= '0;
      end else begin
         ir_q           <= ir_d;
         ir_shift_q     <= ir_shift_d;
         idcode_shift_q <= idcode_shift_d;
         bypass_q       <= bypass_d;
         user_shift_q   <= user_shift_d;
         user_data_q    <= user_data_d;
      end
   end

   // tdo launches on the falling edge so the driver can sample it on the next rise.
   always_ff @(negedge tck or posedge rst) begin
      if (rst) begin
         tdo_q    <= 1'b0;
         tdo_oe_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_oe_q <= tdo_oe_d;
      end
   end

   assign tdo         = tdo_q;
   assign tdo_oe      = tdo_oe_q;
   assign ir          = ir_q;
   assign user_data   = user_data_q;
   assign user_update = update_dr && (ir_q == INSTR_USER);

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Scoreboarded bench for jtag_tap_responder: expected tdo bits are queued as tdi is driven.
module tb_jtag_tap_responder;
   import jtag_tap_pkg::*;

   logic        tck = 1'b0;
   logic        rst = 1'b0;
   logic        tms = 1'b1;
   logic        tdi = 1'b0;
   logic [31:0] user_capture = '0;
   logic        tdo, tdo_oe, user_update;
   logic [3:0]  tap_state, ir;
   logic [31:0] user_data;

   int checks = 0;
   int errors = 0;
   int upd_cnt = 0;
   bit exp_q[$];

   jtag_tap_responder dut (
      .tck          (tck),
      .rst          (rst),
      .tms          (tms),
      .tdi          (tdi),
      .tdo          (tdo),
      .tdo_oe       (tdo_oe),
      .tap_state    (tap_state),
      .ir           (ir),
      .user_capture (user_capture),
      .user_data    (user_data),
      .user_update  (user_update)
   );

   always #10 tck = ~tck;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // One TAP cycle: drive on the fall, sample outputs shortly after, then let the rise happen.
   task automatic tick(input logic t_ms, input logic t_di);
      bit e;
      @(negedge tck);
      tms = t_ms;
      tdi = t_di;
      #2;
      if (tdo_oe && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (tdo !== e) begin
            errors++;
            $display("FAIL tdo_bit got %b want %b", tdo, e);
         end
      end
      if (user_update === 1'b1) upd_cnt++;
      @(posedge tck);
      #1;
   endtask

   task automatic check_queue_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s tdo bits left unchecked %0d want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic ir_scan(input logic [3:0] din);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) exp_q.push_back(i == 0);
      for (int i = 0; i < 4; i++) tick(i == 3, din[i]);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check_queue_drained("ir_scan");
   endtask

   // pause_after > 0 exits to Pause-DR after that many bits, holds 3 cycles, then resumes.
   task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] dexp,
                          input int pause_after);
      logic [31:0] data_before;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < n; i++) exp_q.push_back(dexp[i]);
      for (int i = 0; i < n; i++) begin
         tick((i == n - 1) || (i == pause_after - 1), din[i]);
         if (i == pause_after - 1) begin
            data_before = user_data;
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            checks++;
            if (tap_state !== ST_PAU_DR || user_data !== data_before || upd_cnt != 0) begin
               errors++;
               $display("FAIL pause_hold state %h data %h upd %0d want state %h data %h upd 0",
                        tap_state, user_data, upd_cnt, ST_PAU_DR, data_before);
            end
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
         end
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check_queue_drained("dr_scan");
   endtask

   // USER register model: the scan stream is {tdi bits, captured word}, LSB first.
   task automatic user_scan(input string name, input int n, input logic [63:0] din,
                            input logic [31:0] cap, input int pause_after);
      logic [95:0] s;
      logic [31:0] exp_data;
      s        = {din, cap};
      exp_data = 32'(s >> n);
      user_capture = cap;
      upd_cnt = 0;
      dr_scan(n, din, s[63:0], pause_after);
      checks++;
      if (upd_cnt != 1) begin
         errors++;
         $display("FAIL %s user_update cycles %0d want 1", name, upd_cnt);
      end
      checks++;
      if (user_data !== exp_data) begin
         errors++;
         $display("FAIL %s user_data got %h want %h", name, user_data, exp_data);
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #5;
      checks++;
      if (tap_state !== ST_TLR || ir !== 4'b0010 || user_data !== 32'h0 ||
          tdo !== 1'b0 || tdo_oe !== 1'b0 || user_update !== 1'b0) begin
         errors++;
         $display("FAIL reset_values state %h ir %b data %h tdo %b oe %b upd %b want F 0010 0 0 0 0",
                  tap_state, ir, user_data, tdo, tdo_oe, user_update);
      end
      @(posedge tck);
      @(negedge tck);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      checks++;
      if (tap_state !== ST_TLR) begin
         errors++;
         $display("FAIL tlr_after_tms state %h want %h", tap_state, ST_TLR);
      end
      tick(1'b0, 1'b0);
      checks++;
      if (tap_state !== ST_RTI || ir !== 4'b0010) begin
         errors++;
         $display("FAIL rti_entry state %h ir %b want %h 0010", tap_state, ir, ST_RTI);
      end
   endtask

   task automatic test_idcode;
      dr_scan(32, 64'h0, {32'h0, 32'h149511C3}, 0);
      checks++;
      if (tap_state !== ST_RTI || tdo_oe !== 1'b0) begin
         errors++;
         $display("FAIL idcode_end state %h oe %b want %h 0", tap_state, tdo_oe, ST_RTI);
      end
   endtask

   task automatic test_bypass;
      ir_scan(4'b1111);
      checks++;
      if (ir !== 4'b1111) begin
         errors++;
         $display("FAIL ir_allones got %b want 1111", ir);
      end
      dr_scan(8, 64'hA5, 64'h4A, 0);
      ir_scan(4'b0101);
      checks++;
      if (ir !== 4'b0101) begin
         errors++;
         $display("FAIL ir_0101 got %b want 0101", ir);
      end
      dr_scan(4, 64'hC, 64'h8, 0);
   endtask

   task automatic test_user;
      ir_scan(4'b1000);
      checks++;
      if (ir !== 4'b1000) begin
         errors++;
         $display("FAIL ir_user got %b want 1000", ir);
      end
      user_scan("user32", 32, 64'hDEADBEEF, 32'h12345678, 0);
   endtask

   task automatic test_pause;
      user_scan("user_clear", 32, 64'h0, 32'h12345678, 0);
      user_scan("user_pause", 32, 64'hDEADBEEF, 32'h12345678, 16);
   endtask

   task automatic test_scan_lengths;
      user_scan("user_short", 8, 64'hA5, 32'h12345678, 0);
      user_scan("user_long", 40, 64'h9C_0BADF00D, 32'h87654321, 0);
      checks++;
      if (ir !== 4'b1000) begin
         errors++;
         $display("FAIL ir_stable_dr got %b want 1000", ir);
      end
   endtask

   task automatic test_reset_mid_scan;
      user_capture = 32'h5A5A5A5A;
      upd_cnt = 0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) exp_q.push_back(user_capture[i]);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
      check_queue_drained("mid_scan");
      @(negedge tck);
      #5 rst = 1'b1;
      #1;
      checks++;
      if (tap_state !== ST_TLR || ir !== 4'b0010 || user_data !== 32'h0 ||
          tdo !== 1'b0 || tdo_oe !== 1'b0 || user_update !== 1'b0) begin
         errors++;
         $display("FAIL mid_scan_reset state %h ir %b data %h tdo %b oe %b upd %b want F 0010 0 0 0 0",
                  tap_state, ir, user_data, tdo, tdo_oe, user_update);
      end
      tms = 1'b1;
      repeat (2) @(posedge tck);
      @(negedge tck);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      checks++;
      if (tap_state !== ST_TLR || user_data !== 32'h0 || upd_cnt != 0) begin
         errors++;
         $display("FAIL after_reset state %h data %h upd %0d want F 0 0", tap_state, user_data, upd_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_idcode;
      test_bypass;
      test_user;
      test_pause;
      test_scan_lengths;
      test_reset_mid_scan;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
